// File: rtl/l2_wb_cache.sv
// N-way set-associative write-back / write-allocate L2 with true-LRU replacement.
// Define L2_WB_PERF_CNT_EN to add hit/miss/writeback counters.
module l2_wb_cache #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int CACHE_SIZE = 512,
  parameter int BLOCK_SIZE = 32,
  parameter int NUM_WAYS   = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ADDR_WIDTH-1:0]            l1_cache_addr,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] l1_cache_data_in,
  input  logic                             l1_cache_read,
  input  logic                             l1_cache_write,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] l1_block_data_out,
  output logic                             l1_cache_ready,
  output logic                             l1_cache_hit,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_out,
  output logic                             mem_read,
  output logic                             mem_write,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_block,
  input  logic                             mem_ready
`ifdef L2_WB_PERF_CNT_EN
  ,output logic [31:0]                     hit_count,
  output logic [31:0]                      miss_count,
  output logic [31:0]                      wb_count
`endif
);
  localparam int BW   = BLOCK_SIZE * DATA_WIDTH;
  localparam int OFFS = $clog2(BLOCK_SIZE);
  localparam int SETS = CACHE_SIZE / BLOCK_SIZE / NUM_WAYS;
  localparam int IDXW = $clog2(SETS);
  localparam int TAGW = ADDR_WIDTH - IDXW - OFFS;
  localparam int WAYW = $clog2(NUM_WAYS);

  typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, FILL} state_t;
  typedef struct packed {
    logic [TAGW-1:0] tag;
    logic [IDXW-1:0] idx;
    logic [BW-1:0]   data;
    logic            wr;
  } req_t;

  state_t state, nxt;
  req_t   req;

  logic [BW-1:0]     datas [SETS][NUM_WAYS];
  logic [TAGW-1:0]   tags  [SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] valid [SETS];
  logic [NUM_WAYS-1:0] dirty [SETS];
  logic [WAYW-1:0]   age   [SETS][NUM_WAYS];
  logic [WAYW-1:0]   vic_way;

  logic            hit, inv_found, vic_dirty;
  logic [WAYW-1:0] hit_way, victim;
  logic            wr_en, inst, inst_dirty, touch, clr_dirty, done, done_hit;
  logic [WAYW-1:0] wr_way;
  logic [BW-1:0]   wr_data, rd_data;

  logic unused_addr;
  assign unused_addr = ^l1_cache_addr[OFFS-1:0];

  // Victim: lowest invalid way, else the way whose age is the maximum (ages are a permutation).
  always_comb begin
    hit = 1'b0; hit_way = '0; inv_found = 1'b0; victim = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (!hit && valid[req.idx][w] && tags[req.idx][w] == req.tag) begin
        hit = 1'b1; hit_way = WAYW'(w);
      end
    for (int w = 0; w < NUM_WAYS; w++)
      if (!inv_found && !valid[req.idx][w]) begin
        inv_found = 1'b1; victim = WAYW'(w);
      end
    if (!inv_found)
      for (int w = 0; w < NUM_WAYS; w++)
        if (age[req.idx][w] == WAYW'(NUM_WAYS-1)) victim = WAYW'(w);
    vic_dirty = valid[req.idx][victim] && dirty[req.idx][victim];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:      if (l1_cache_read || l1_cache_write) nxt = LOOKUP;
      LOOKUP:    if (hit)            nxt = IDLE;
                 else if (vic_dirty) nxt = WRITEBACK;
                 else if (req.wr)    nxt = IDLE;
                 else                nxt = FILL;
      WRITEBACK: if (mem_ready) nxt = req.wr ? IDLE : FILL;
      FILL:      if (mem_ready) nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_read     = (state == FILL);
    mem_write    = (state == WRITEBACK);
    mem_addr     = '0;
    mem_data_out = '0;
    if (state == WRITEBACK) begin
      mem_addr     = {tags[req.idx][vic_way], req.idx, {OFFS{1'b0}}};
      mem_data_out = datas[req.idx][vic_way];
    end else if (state == FILL)
      mem_addr = {req.tag, req.idx, {OFFS{1'b0}}};
  end

  // Array update controls; inst writes tag/valid/dirty of wr_way.
  always_comb begin
    wr_en = 1'b0; inst = 1'b0; inst_dirty = 1'b1; touch = 1'b0; clr_dirty = 1'b0;
    done = 1'b0; done_hit = 1'b0;
    wr_way  = hit ? hit_way : victim;
    wr_data = req.data;
    rd_data = req.wr ? req.data : datas[req.idx][hit_way];
    case (state)
      LOOKUP:
        if (hit) begin
          touch = 1'b1; done = 1'b1; done_hit = 1'b1;
          wr_en = req.wr; inst = req.wr;
        end else if (!vic_dirty && req.wr) begin
          wr_en = 1'b1; inst = 1'b1; touch = 1'b1; done = 1'b1;
        end
      WRITEBACK:
        if (mem_ready) begin
          clr_dirty = 1'b1;
          wr_way = vic_way;
          if (req.wr) begin wr_en = 1'b1; inst = 1'b1; touch = 1'b1; done = 1'b1; end
        end
      FILL:
        if (mem_ready) begin
          wr_way = vic_way; wr_data = mem_data_block; rd_data = mem_data_block;
          wr_en = 1'b1; inst = 1'b1; inst_dirty = 1'b0; touch = 1'b1; done = 1'b1;
        end
      default: ;
    endcase
  end

  // Block storage and tags carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (wr_en) datas[req.idx][wr_way] <= wr_data;
    if (inst)  tags[req.idx][wr_way]  <= req.tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req <= '0; vic_way <= '0;
      l1_cache_ready <= 1'b0; l1_cache_hit <= 1'b0; l1_block_data_out <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0; dirty[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) age[s][w] <= WAYW'(w);
      end
`ifdef L2_WB_PERF_CNT_EN
      hit_count <= '0; miss_count <= '0; wb_count <= '0;
`endif
    end else begin
      if (state == IDLE && (l1_cache_read || l1_cache_write)) begin
        req.tag  <= l1_cache_addr[ADDR_WIDTH-1 -: TAGW];
        req.idx  <= l1_cache_addr[OFFS +: IDXW];
        req.data <= l1_cache_data_in;
        req.wr   <= l1_cache_write;
      end
      if (state == LOOKUP) vic_way <= victim;
      if (clr_dirty) dirty[req.idx][vic_way] <= 1'b0;
      if (inst) begin
        valid[req.idx][wr_way] <= 1'b1;
        dirty[req.idx][wr_way] <= inst_dirty;
      end
      if (touch) begin
        for (int w = 0; w < NUM_WAYS; w++)
          if (age[req.idx][w] < age[req.idx][wr_way])
            age[req.idx][w] <= age[req.idx][w] + WAYW'(1);
        age[req.idx][wr_way] <= '0;
      end
      l1_cache_ready <= done;
      l1_cache_hit   <= done_hit;
      if (done) l1_block_data_out <= rd_data;
`ifdef L2_WB_PERF_CNT_EN
      if (state == LOOKUP && hit)       hit_count  <= hit_count + 32'd1;
      if (state == LOOKUP && !hit)      miss_count <= miss_count + 32'd1;
      if (state == WRITEBACK && mem_ready) wb_count <= wb_count + 32'd1;
`endif
    end
  end
endmodule
